sprite_rom_arbiter: RTL and testbench

Shares one single-port sprite ROM (14-bit address, 12-bit RGB 4:4:4 pixel, registered read) between two pixel requesters: the P1 and P2 sprite renderers. Arbitration is round-robin, at most one grant per cycle, and each read is fully pipelined. Returned pixels are routed to the owning requester with a valid strobe. Sits between the renderers and the sprite ROM in the street fighter video path.

---
 rtl/sprite_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 41 ++++
 rtl/sprite_rom_arbiter.sv | 133 +++++++++++++
 tb/tb_sprite_rom_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite ROM arbiter.
// Holds the default ROM geometry, the transparency key colour and the
// owner-tag encoding that travels down the read pipeline.
package sprite_pkg;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 12;
    localparam logic [11:0] KEY_COLOR = 12'hF0F;

    // Owner encoding; also the bit index of each requester in req/gnt vectors.
    localparam logic TAG_P1 = 1'b0;
    localparam logic TAG_P2 = 1'b1;

    typedef struct packed {
        logic valid;
        logic owner;
    } tag_t;

    function automatic tag_t make_tag(input logic valid, input logic owner);
        tag_t t;
        t.valid = valid;
        t.owner = owner;
        return t;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with at most one grant per cycle.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high; forces gnt to 0 while high
//   req   - request vector, bit 0 = P1, bit 1 = P2
//   gnt   - combinational one-hot (or zero) grant vector
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    import sprite_pkg::*;

    // Requester favoured on contention: the one not granted most recently.
    logic prio_q;

    always_comb begin
        gnt = 2'b00;
        if (!reset) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (prio_q == TAG_P1) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Pointer only moves on an actual grant, so withdrawn requests leave it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= TAG_P1;
        end else if (gnt[0]) begin
            prio_q <= TAG_P2;
        end else if (gnt[1]) begin
            prio_q <= TAG_P1;
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one registered-read sprite ROM between the P1 and P2 renderers.
// Round-robin arbitration, one read accepted per cycle, fully pipelined;
// returned pixels are steered back to their owner with a one-cycle valid.
// Optional feature macro: TRANSPARENT_KEY_EN adds pN_rtransp flags that
// mark returned pixels equal to KEY_COLOR.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   pN_req, pN_addr             - requester read request and pixel address
//   pN_gnt                      - request accepted this cycle (combinational)
//   pN_rvalid, pN_rdata         - returned pixel and its valid strobe
//   rom_addr, rom_pixel         - ROM address (registered) and ROM read data
//   pN_rtransp                  - returned pixel is the key colour (feature only)
module sprite_rom_arbiter #(
    parameter int unsigned ADDR_W  = sprite_pkg::ADDR_W,
    parameter int unsigned DATA_W  = sprite_pkg::DATA_W,
    parameter int unsigned ROM_LAT = 1
`ifdef TRANSPARENT_KEY_EN
    ,
    parameter logic [DATA_W-1:0] KEY_COLOR = sprite_pkg::KEY_COLOR
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p1_req,
    input  logic [ADDR_W-1:0] p1_addr,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    input  logic              p2_req,
    input  logic [ADDR_W-1:0] p2_addr,
    output logic              p2_gnt,
    output logic              p2_rvalid,
    output logic [DATA_W-1:0] p2_rdata,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_pixel
`ifdef TRANSPARENT_KEY_EN
    ,
    output logic              p1_rtransp,
    output logic              p2_rtransp
`endif
);
    import sprite_pkg::*;

    logic [1:0] req;
    logic [1:0] gnt;

    assign req = {p2_req, p1_req};

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .gnt   (gnt)
    );

    assign p1_gnt = gnt[0];
    assign p2_gnt = gnt[1];

    // Stage 0 sits beside rom_addr; stage ROM_LAT lines up with the pixel on
    // rom_pixel, which is then registered once into the return outputs.
    tag_t [ROM_LAT:0]  tag_q;
    tag_t              tail;
    logic              ret_p1;
    logic              ret_p2;

    logic [ADDR_W-1:0] rom_addr_q;
    logic              p1_rvalid_q;
    logic              p2_rvalid_q;
    logic [DATA_W-1:0] p1_rdata_q;
    logic [DATA_W-1:0] p2_rdata_q;

    assign tail   = tag_q[ROM_LAT];
    assign ret_p1 = tail.valid && (tail.owner == TAG_P1);
    assign ret_p2 = tail.valid && (tail.owner == TAG_P2);

`ifdef TRANSPARENT_KEY_EN
    logic p1_rtransp_q;
    logic p2_rtransp_q;
    logic is_key;

    assign is_key = (rom_pixel == KEY_COLOR);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr_q  <= '0;
            tag_q       <= '0;
            p1_rvalid_q <= 1'b0;
            p2_rvalid_q <= 1'b0;
            p1_rdata_q  <= '0;
            p2_rdata_q  <= '0;
`ifdef TRANSPARENT_KEY_EN
            p1_rtransp_q <= 1'b0;
            p2_rtransp_q <= 1'b0;
`endif
        end else begin
            // Idle cycles hold the last address.
            if (gnt[0]) begin
                rom_addr_q <= p1_addr;
            end else if (gnt[1]) begin
                rom_addr_q <= p2_addr;
            end

            if (ROM_LAT > 0) begin
                tag_q <= {tag_q[ROM_LAT-1:0], make_tag(|gnt, gnt[1])};
            end

            p1_rvalid_q <= ret_p1;
            p2_rvalid_q <= ret_p2;
            if (ret_p1) begin
                p1_rdata_q <= rom_pixel;
            end
            if (ret_p2) begin
                p2_rdata_q <= rom_pixel;
            end
`ifdef TRANSPARENT_KEY_EN
            p1_rtransp_q <= ret_p1 && is_key;
            p2_rtransp_q <= ret_p2 && is_key;
`endif
        end
    end

    assign rom_addr  = rom_addr_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p2_rvalid = p2_rvalid_q;
    assign p1_rdata  = p1_rdata_q;
    assign p2_rdata  = p2_rdata_q;
`ifdef TRANSPARENT_KEY_EN
    assign p1_rtransp = p1_rtransp_q;
    assign p2_rtransp = p2_rtransp_q;
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a one-cycle registered ROM model.
module tb_sprite_rom_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p1_req = 1'b0;
    logic [13:0] p1_addr = '0;
    logic        p1_gnt;
    logic        p1_rvalid;
    logic [11:0] p1_rdata;
    logic        p2_req = 1'b0;
    logic [13:0] p2_addr = '0;
    logic        p2_gnt;
    logic        p2_rvalid;
    logic [11:0] p2_rdata;
    logic [13:0] rom_addr;
    logic [11:0] rom_pixel;
`ifdef TRANSPARENT_KEY_EN
    logic        p1_rtransp;
    logic        p2_rtransp;
`endif

    int total = 0;
    int bad   = 0;

    logic [11:0] rom_mem [0:16383];

    always #5 clk = ~clk;

    always_ff @(posedge clk) rom_pixel <= rom_mem[rom_addr];

    sprite_rom_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .p1_req    (p1_req),
        .p1_addr   (p1_addr),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .p2_req    (p2_req),
        .p2_addr   (p2_addr),
        .p2_gnt    (p2_gnt),
        .p2_rvalid (p2_rvalid),
        .p2_rdata  (p2_rdata),
        .rom_addr  (rom_addr),
        .rom_pixel (rom_pixel)
`ifdef TRANSPARENT_KEY_EN
        ,
        .p1_rtransp(p1_rtransp),
        .p2_rtransp(p2_rtransp)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Start of a new cycle, just after the active edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rst();
        cyc();
        reset   = 1'b1;
        p1_req  = 1'b0;
        p2_req  = 1'b0;
        cyc();
        reset   = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) rom_mem[i] = 12'(i * 37 + 5);
        rom_mem[14'h0040] = 12'hABC;
        rom_mem[14'h3FFF] = 12'hF0F;
        rom_mem[14'h0000] = 12'hF0E;

        // Reset: grants forced low even with both requests up.
        cyc();
        p1_req = 1'b1;
        p2_req = 1'b1;
        #1;
        chk("rst_p1_gnt", p1_gnt, 0);
        chk("rst_p2_gnt", p2_gnt, 0);
        cyc();
        #1;
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_p1_rvalid", p1_rvalid, 0);
        chk("rst_p2_rvalid", p2_rvalid, 0);
        chk("rst_p1_rdata", p1_rdata, 0);
        chk("rst_p2_rdata", p2_rdata, 0);

        // Dual contention for 6 cycles: P1, P2, P1, ... each returning 3 cycles later.
        for (int k = 0; k < 10; k++) begin
            cyc();
            reset   = 1'b0;
            p1_req  = (k < 6);
            p2_req  = (k < 6);
            p1_addr = 14'(14'h100 + k);
            p2_addr = 14'(14'h200 + k);
            #1;
            if (k < 6) begin
                chk("cont_p1_gnt", p1_gnt, (k % 2 == 0));
                chk("cont_p2_gnt", p2_gnt, (k % 2 == 1));
            end
            if (k == 1) chk("cont_rom_addr", rom_addr, 14'h100);
            if (k >= 3 && k < 9) begin
                if ((k - 3) % 2 == 0) begin
                    chk("cont_p1_rvalid", p1_rvalid, 1);
                    chk("cont_p2_rvalid", p2_rvalid, 0);
                    chk("cont_p1_rdata", p1_rdata, rom_mem[14'h100 + k - 3]);
                end else begin
                    chk("cont_p2_rvalid", p2_rvalid, 1);
                    chk("cont_p1_rvalid", p1_rvalid, 0);
                    chk("cont_p2_rdata", p2_rdata, rom_mem[14'h200 + k - 3]);
                end
            end else begin
                chk("cont_idle_p1_rvalid", p1_rvalid, 0);
                chk("cont_idle_p2_rvalid", p2_rvalid, 0);
            end
        end

        // Single P1 request at 0x40.
        rst();
        cyc();
        p1_req  = 1'b1;
        p1_addr = 14'h0040;
        #1;
        chk("single_p1_gnt", p1_gnt, 1);
        chk("single_p2_gnt", p2_gnt, 0);
        cyc();
        p1_req  = 1'b0;
        p1_addr = 14'h1234;
        #1;
        chk("single_rom_addr", rom_addr, 14'h0040);
        chk("single_p1_gnt_drop", p1_gnt, 0);
        cyc();
        #1;
        chk("single_early_rvalid", p1_rvalid, 0);
        chk("single_rom_addr_hold", rom_addr, 14'h0040);
        cyc();
        #1;
        chk("single_p1_rvalid", p1_rvalid, 1);
        chk("single_p1_rdata", p1_rdata, 12'hABC);
        chk("single_p2_rvalid", p2_rvalid, 0);
        cyc();
        #1;
        chk("single_rvalid_pulse", p1_rvalid, 0);
        chk("single_rdata_hold", p1_rdata, 12'hABC);

        // P2 streams one 128-pixel row back to back.
        for (int k = 0; k < 132; k++) begin
            cyc();
            p2_req  = (k < 128);
            p2_addr = 14'(k);
            #1;
            if (k < 128) chk("burst_p2_gnt", p2_gnt, 1);
            if (k >= 3 && k < 131) begin
                chk("burst_p2_rvalid", p2_rvalid, 1);
                chk("burst_p2_rdata", p2_rdata, rom_mem[k - 3]);
            end else begin
                chk("burst_p2_idle", p2_rvalid, 0);
            end
            chk("burst_p1_rvalid", p1_rvalid, 0);
        end

        // Reset while two reads are in flight.
        rst();
        cyc();
        p1_req  = 1'b1;
        p2_req  = 1'b1;
        p1_addr = 14'h0010;
        p2_addr = 14'h0011;
        #1;
        chk("mid_p1_gnt", p1_gnt, 1);
        chk("mid_p2_gnt0", p2_gnt, 0);
        cyc();
        p1_req = 1'b0;
        #1;
        chk("mid_p2_gnt", p2_gnt, 1);
        cyc();
        reset  = 1'b1;
        p1_req = 1'b1;
        p2_req = 1'b1;
        #1;
        chk("mid_rst_p1_gnt", p1_gnt, 0);
        chk("mid_rst_p2_gnt", p2_gnt, 0);
        cyc();
        reset = 1'b0;
        #1;
        chk("mid_p1_rvalid_a", p1_rvalid, 0);
        chk("mid_p2_rvalid_a", p2_rvalid, 0);
        chk("mid_rom_addr", rom_addr, 0);
        chk("mid_p1_rdata", p1_rdata, 0);
        chk("mid_regrant_p1", p1_gnt, 1);
        chk("mid_regrant_p2", p2_gnt, 0);
        cyc();
        p1_req = 1'b0;
        p2_req = 1'b0;
        #1;
        chk("mid_p1_rvalid_b", p1_rvalid, 0);
        chk("mid_p2_rvalid_b", p2_rvalid, 0);
        chk("mid_rom_addr_new", rom_addr, 14'h0010);
        cyc();
        #1;
        chk("mid_p1_rvalid_c", p1_rvalid, 0);
        chk("mid_p2_rvalid_c", p2_rvalid, 0);
        cyc();
        #1;
        chk("mid_new_p1_rvalid", p1_rvalid, 1);
        chk("mid_new_p1_rdata", p1_rdata, rom_mem[14'h0010]);
        chk("mid_new_p2_rvalid", p2_rvalid, 0);

        // P2 withdraws before being granted.
        rst();
        cyc();
        p1_req  = 1'b1;
        p2_req  = 1'b1;
        p1_addr = 14'h0020;
        p2_addr = 14'h0021;
        #1;
        chk("wd_p1_gnt", p1_gnt, 1);
        chk("wd_p2_gnt", p2_gnt, 0);
        cyc();
        p1_req = 1'b0;
        p2_req = 1'b0;
        #1;
        chk("wd_p2_gnt_after", p2_gnt, 0);
        cyc();
        #1;
        chk("wd_p2_rvalid_a", p2_rvalid, 0);
        cyc();
        #1;
        chk("wd_p1_rvalid", p1_rvalid, 1);
        chk("wd_p1_rdata", p1_rdata, rom_mem[14'h0020]);
        chk("wd_p2_rvalid_b", p2_rvalid, 0);
        cyc();
        p1_req = 1'b1;
        p2_req = 1'b1;
        #1;
        chk("wd_next_p2_gnt", p2_gnt, 1);
        chk("wd_next_p1_gnt", p1_gnt, 0);
        cyc();
        p1_req = 1'b0;
        p2_req = 1'b0;
        #1;
        cyc();
        #1;
        cyc();
        #1;
        chk("wd_p2_late_rvalid", p2_rvalid, 1);
        chk("wd_p2_late_rdata", p2_rdata, rom_mem[14'h0021]);

        // Top-of-space address, wrap to 0, and the transparency key.
        rst();
        cyc();
        p1_req  = 1'b1;
        p1_addr = 14'h3FFF;
        #1;
        chk("key_gnt_a", p1_gnt, 1);
        cyc();
        p1_addr = 14'h0000;
        #1;
        chk("key_gnt_b", p1_gnt, 1);
        chk("key_rom_addr_a", rom_addr, 14'h3FFF);
        cyc();
        p1_req = 1'b0;
        #1;
        chk("key_rom_addr_b", rom_addr, 14'h0000);
        cyc();
        #1;
        chk("key_rvalid_a", p1_rvalid, 1);
        chk("key_rdata_a", p1_rdata, 12'hF0F);
`ifdef TRANSPARENT_KEY_EN
        chk("key_p1_rtransp_a", p1_rtransp, 1);
        chk("key_p2_rtransp_a", p2_rtransp, 0);
`endif
        cyc();
        #1;
        chk("key_rvalid_b", p1_rvalid, 1);
        chk("key_rdata_b", p1_rdata, 12'hF0E);
`ifdef TRANSPARENT_KEY_EN
        chk("key_p1_rtransp_b", p1_rtransp, 0);
`endif
        cyc();
        #1;
        chk("key_rvalid_c", p1_rvalid, 0);
`ifdef TRANSPARENT_KEY_EN
        chk("key_p1_rtransp_c", p1_rtransp, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
